// File: rtl/nibble_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nibble_reg_rr_arbiter
//
// Purpose:
//   Shares one packed register of WIDTH 4-bit nibbles between NREQ requesters.
//   A round-robin arbiter accepts at most one beat per cycle. Each beat writes
//   only the nibbles selected by its mask. A requester can hold a lock so that
//   it keeps ownership across a multi-beat update. A lock that stays idle for
//   LOCK_TIMEOUT cycles is released.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   req_valid  in   [NREQ]               per-requester write request
//   req_ready  out  [NREQ]               grant, combinational, one-hot or zero
//   req_data   in   [NREQ][WIDTH][4]     write data per requester
//   req_mask   in   [NREQ][WIDTH]        per-nibble write enable (1 = write)
//   req_lock   in   [NREQ]               keep ownership after this beat
//   clear      in   reload RESET_VALUE and drop any lock (beats blocked)
//   out        out  [WIDTH][4]           shared register
//   out_upd    out  one-cycle pulse, one cycle after an accepted beat
//   out_owner  out  [IDX_W]              index of the last accepted writer
//   locked     out  high while the arbiter is in the LOCKED state
//
// Handshake: a beat from requester i is accepted in a cycle where
//   req_valid[i] && req_ready[i]. req_ready never depends on any requester
//   other than the arbiter's choice and is zero while clear is high.
// -----------------------------------------------------------------------------
module nibble_reg_rr_arbiter #(
    parameter int                 NREQ         = 4,
    parameter int                 WIDTH        = 8,
    parameter logic [WIDTH*4-1:0] RESET_VALUE  = '1,
    parameter int                 LOCK_TIMEOUT = 16,
    localparam int                IDX_W        = $clog2(NREQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NREQ-1:0]                  req_valid,
    output logic [NREQ-1:0]                  req_ready,
    input  logic [NREQ-1:0][WIDTH-1:0][3:0]  req_data,
    input  logic [NREQ-1:0][WIDTH-1:0]       req_mask,
    input  logic [NREQ-1:0]                  req_lock,
    input  logic                             clear,
    output logic [WIDTH-1:0][3:0]            out,
    output logic                             out_upd,
    output logic [IDX_W-1:0]                 out_owner,
    output logic                             locked
);

    // Idle-cycle counter is wide enough to hold LOCK_TIMEOUT-1.
    localparam int CNT_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                   state_q,   state_d;
    logic [IDX_W-1:0]         ptr_q,     ptr_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic [WIDTH-1:0][3:0]    out_q,     out_d;
    logic                     out_upd_q, out_upd_d;
    // While LOCKED, the lock holder is always the last accepted writer,
    // so out_owner doubles as the lock owner.
    logic [IDX_W-1:0]         owner_q,   owner_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                     grant_valid;
    logic [IDX_W-1:0]         grant_idx;

    // Wrap-around successor of a requester index.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        if (!clear) begin
            if (state_q == ST_LOCKED) begin
                // Only the lock owner may be granted.
                if (req_valid[owner_q]) begin
                    grant_valid = 1'b1;
                    grant_idx   = owner_q;
                end
            end else begin
                // Search ptr, ptr+1, ... wrapping mod NREQ; first valid wins.
                for (int k = 0; k < NREQ; k++) begin
                    cand = int'(ptr_q) + k;
                    if (cand >= NREQ) begin
                        cand = cand - NREQ;
                    end
                    cand_idx = IDX_W'(cand);
                    if (!grant_valid && req_valid[cand_idx]) begin
                        grant_valid = 1'b1;
                        grant_idx   = cand_idx;
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_upd_d = 1'b0;
        owner_d   = owner_q;

        if (clear) begin
            // Pointer and owner are deliberately left alone.
            out_d   = RESET_VALUE;
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (grant_valid) begin
            for (int n = 0; n < WIDTH; n++) begin
                if (req_mask[grant_idx][n]) begin
                    out_d[n] = req_data[grant_idx][n];
                end
            end
            // An all-zero mask still counts as an accepted write.
            out_upd_d = 1'b1;
            owner_d   = grant_idx;
            cnt_d     = '0;
            // Pointer moves past the winner on every accept; while a lock
            // is held it is not consulted, and on release it is set to the
            // same value again, so updating it here is harmless.
            ptr_d     = next_idx(grant_idx);
            state_d   = req_lock[grant_idx] ? ST_LOCKED : ST_IDLE;
        end else if (state_q == ST_LOCKED && LOCK_TIMEOUT > 0) begin
            // cnt_q counts idle LOCKED cycles already completed; this cycle
            // is the LOCK_TIMEOUT-th idle one when cnt_q == LOCK_TIMEOUT-1,
            // so the lock is held for exactly LOCK_TIMEOUT idle cycles.
            if (cnt_q == CNT_LAST) begin
                state_d = ST_IDLE;
                ptr_d   = next_idx(owner_q);
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers (FSM state and all registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            out_q     <= RESET_VALUE;
            out_upd_q <= 1'b0;
            owner_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_upd_q <= out_upd_d;
            owner_q   <= owner_d;
        end
    end

    assign out       = out_q;
    assign out_upd   = out_upd_q;
    assign out_owner = owner_q;
    assign locked    = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_nibble_reg_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nibble_reg_rr_arbiter
//
// Self-checking bench for nibble_reg_rr_arbiter (NREQ=4, WIDTH=8,
// LOCK_TIMEOUT=16). Inputs change on the falling edge, req_ready is sampled
// 1 ns later, registered outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_nibble_reg_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int TMO   = 16;
    localparam logic [31:0] RV = 32'hFFFF_FFFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]                 req_valid = '0;
    logic [NREQ-1:0]                 req_ready;
    logic [NREQ-1:0][WIDTH-1:0][3:0] req_data = '0;
    logic [NREQ-1:0][WIDTH-1:0]      req_mask = '0;
    logic [NREQ-1:0]                 req_lock = '0;
    logic                            clear = 1'b0;
    logic [WIDTH-1:0][3:0]           out;
    logic                            out_upd;
    logic [1:0]                      out_owner;
    logic                            locked;

    nibble_reg_rr_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .RESET_VALUE(RV), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_mask(req_mask), .req_lock(req_lock),
        .clear(clear),
        .out(out), .out_upd(out_upd), .out_owner(out_owner), .locked(locked)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Plain integer bookkeeping of the arbitration rules.
    int          m_ptr    = 0;
    int          m_owner  = 0;
    int          m_idle   = 0;
    bit          m_locked = 1'b0;
    bit          m_upd    = 1'b0;
    logic [31:0] m_out    = RV;

    // Scoreboard: every accepted beat queues the value `out` must show
    // on its out_upd pulse.
    logic [31:0] exp_q[$];

    function automatic int model_grant();
        if (clear) return -1;
        if (m_locked) return req_valid[2'(m_owner)] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (req_valid[2'(c)]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        logic [3:0] r;
        g = model_grant();
        r = '0;
        if (g >= 0) r[2'(g)] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_idle = 0;
        m_locked = 1'b0; m_upd = 1'b0; m_out = RV;
        exp_q.delete();
    endtask

    task automatic model_update(input int g);
        if (clear) begin
            m_out = RV; m_locked = 1'b0; m_idle = 0; m_upd = 1'b0;
        end else if (g >= 0) begin
            for (int n = 0; n < WIDTH; n++) begin
                if (req_mask[2'(g)][3'(n)]) m_out[4*n +: 4] = req_data[2'(g)][3'(n)];
            end
            m_upd = 1'b1;
            m_owner = g;
            m_ptr = (g + 1) % NREQ;
            m_locked = req_lock[2'(g)];
            m_idle = 0;
            exp_q.push_back(m_out);
        end else begin
            m_upd = 1'b0;
            if (m_locked) begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_locked = 1'b0;
                    m_ptr = (m_owner + 1) % NREQ;
                    m_idle = 0;
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] v, input logic [3:0] lk, input logic clr,
                         input logic [31:0] d, input logic [7:0] m);
        req_valid = v;
        req_lock  = lk;
        clear     = clr;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i] = d;
            req_mask[i] = m;
        end
    endtask

    // Advances one rising edge, keeps the model in step and runs the
    // scoreboard. Returns 1 ns after the edge.
    task automatic clock_edge();
        int g;
        logic [31:0] e;
        g = model_grant();
        @(posedge clk);
        if (reset) model_reset();
        else model_update(g);
        #1;
        if (!reset && out_upd === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_upd: got out_upd=1 with out=%0h expected no update", out);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out", out, e);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(4'b0, 4'b0, 1'b0, 32'h0, 8'h0);
        clock_edge();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e_out, input logic e_upd,
                              input logic [1:0] e_own, input logic e_lck);
        chk({tag, "_out"}, out, e_out);
        chk({tag, "_upd"}, out_upd, e_upd);
        chk({tag, "_owner"}, out_owner, e_own);
        chk({tag, "_locked"}, locked, e_lck);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  lock;
        logic        clr;
        logic [31:0] data;
        logic [7:0]  mask;
        logic [3:0]  exp_ready;
        logic [31:0] exp_out;
        logic        exp_upd;
        logic [1:0]  exp_owner;
        logic        exp_locked;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int dens;
        // Round-robin sweep, masked write, lock hold/release, clear.
        vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0001, 32'hFFFFFFFF, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0010, 32'hFFFFFFFF, 1'b1, 2'd1, 1'b0};
        vecs[2]  = '{4'b1111, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0100, 32'hFFFFFFFF, 1'b1, 2'd2, 1'b0};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b1000, 32'hFFFFFFFF, 1'b1, 2'd3, 1'b0};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0001, 32'hFFFFFFFF, 1'b1, 2'd0, 1'b0};
        vecs[5]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0000, 32'hFFFFFFFF, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{4'b0100, 4'b0000, 1'b0, 32'h12345678, 8'h0F, 4'b0100, 32'hFFFF5678, 1'b1, 2'd2, 1'b0};
        vecs[7]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        8'hFF, 4'b0000, 32'hFFFF5678, 1'b0, 2'd2, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0010, 1'b0, 32'hAAAAAAAA, 8'hFF, 4'b0010, 32'hAAAAAAAA, 1'b1, 2'd1, 1'b1};
        vecs[9]  = '{4'b1011, 4'b0010, 1'b0, 32'h11111111, 8'h01, 4'b0010, 32'hAAAAAAA1, 1'b1, 2'd1, 1'b1};
        vecs[10] = '{4'b1001, 4'b0000, 1'b0, 32'h0,        8'hFF, 4'b0000, 32'hAAAAAAA1, 1'b0, 2'd1, 1'b1};
        vecs[11] = '{4'b1011, 4'b0000, 1'b0, 32'h22222222, 8'hF0, 4'b0010, 32'h2222AAA1, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{4'b1001, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b1000, 32'h2222AAA1, 1'b1, 2'd3, 1'b0};
        vecs[13] = '{4'b1111, 4'b0000, 1'b1, 32'h0,        8'hFF, 4'b0000, 32'hFFFFFFFF, 1'b0, 2'd3, 1'b0};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        8'h00, 4'b0000, 32'hFFFFFFFF, 1'b0, 2'd3, 1'b0};

        // ---- reset state ----
        @(negedge clk);
        do_reset();
        #1;
        chk("rst_ready", req_ready, 4'b0000);
        check_outs("rst", RV, 1'b0, 2'd0, 1'b0);
        @(negedge clk);

        // ---- table ----
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].lock, vecs[i].clr, vecs[i].data, vecs[i].mask);
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, vecs[i].exp_ready);
            clock_edge();
            check_outs($sformatf("tbl%0d", i), vecs[i].exp_out, vecs[i].exp_upd,
                       vecs[i].exp_owner, vecs[i].exp_locked);
            @(negedge clk);
        end

        // ---- lock timeout: owner 0 goes quiet, requester 1 waits ----
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0, 32'h0, 8'h00);
        #1;
        chk("to_lock_ready", req_ready, 4'b0001);
        clock_edge();
        chk("to_lock_locked", locked, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= TMO; k++) begin
            drive(4'b0010, 4'b0000, 1'b0, 32'h0, 8'h00);
            #1;
            chk($sformatf("to_c%0d_ready", k), req_ready, 4'b0000);
            clock_edge();
            chk($sformatf("to_c%0d_locked", k), locked, (k < TMO) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        drive(4'b0010, 4'b0000, 1'b0, 32'h0, 8'h00);
        #1;
        chk("to_after_ready", req_ready, 4'b0010);
        clock_edge();
        chk("to_after_owner", out_owner, 2'd1);
        @(negedge clk);

        // ---- clear while locked, requester 2 waiting ----
        do_reset();
        drive(4'b0001, 4'b0001, 1'b0, 32'h0, 8'hFF);
        #1;
        clock_edge();
        check_outs("clr_lock", 32'h0, 1'b1, 2'd0, 1'b1);
        @(negedge clk);
        drive(4'b0100, 4'b0000, 1'b1, 32'h0, 8'hFF);
        #1;
        chk("clr_ready", req_ready, 4'b0000);
        clock_edge();
        check_outs("clr", RV, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        drive(4'b0100, 4'b0000, 1'b0, 32'h0, 8'h00);
        #1;
        chk("clr_next_ready", req_ready, 4'b0100);
        clock_edge();
        chk("clr_next_owner", out_owner, 2'd2);
        @(negedge clk);

        // ---- reset in the middle of a lock with a beat pending ----
        do_reset();
        drive(4'b1000, 4'b1000, 1'b0, 32'h55555555, 8'hFF);
        #1;
        clock_edge();
        check_outs("mrst_lock", 32'h55555555, 1'b1, 2'd3, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(4'b1000, 4'b0000, 1'b0, 32'h0, 8'hFF);
        clock_edge();
        check_outs("mrst", RV, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        drive(4'b1111, 4'b0000, 1'b0, 32'h0, 8'h00);
        #1;
        chk("mrst_ptr_ready", req_ready, 4'b0001);
        clock_edge();
        @(negedge clk);

        // ---- randomized run against the model ----
        do_reset();
        dens = 50;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 60 == 0) dens = $urandom_range(5, 95);
            reset = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < dens);
                req_lock[i]  = ($urandom_range(0, 99) < 30);
                req_data[i]  = $urandom;
                req_mask[i]  = 8'($urandom_range(0, 255));
            end
            #1;
            if (!reset) chk("rnd_ready", req_ready, model_ready());
            clock_edge();
            check_outs("rnd", m_out, m_upd, 2'(m_owner), m_locked);
            @(negedge clk);
        end
        reset = 1'b0;
        drive(4'b0, 4'b0, 1'b0, 32'h0, 8'h0);
        #1;
        clock_edge();
        chk("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
